// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiplier arbiter: datapath word width and FSM state encoding.
package mm_pkg;

    localparam int WORD_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        BUSY   = 2'd2,
        RETURN = 2'd3
    } state_t;

    function automatic logic [1:0] oneHot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mm_arbiter_if.sv
// Bundle of requester-side and multiplier-side handshakes around mm_arbiter.
// slave is the arbiter's view, master the view of the surrounding requesters and multiplier.
interface mm_arbiter_if
    import mm_pkg::*;
#(
    parameter int m = 4,
    parameter int p = 4,
    parameter int n = 4
);

    logic [m*p*WORD_WIDTH-1:0] req_A0, req_A1;
    logic [p*n*WORD_WIDTH-1:0] req_B0, req_B1;
    logic [1:0]                req_stb;
    logic [1:0]                req_ack;
    logic [m*n*WORD_WIDTH-1:0] rsp_C;
    logic [1:0]                rsp_stb;
    logic [1:0]                rsp_ack;
    logic                      rsp_err;
    logic [m*p*WORD_WIDTH-1:0] mm_A;
    logic [p*n*WORD_WIDTH-1:0] mm_B;
    logic                      mm_a_stb, mm_b_stb;
    logic                      mm_a_ack, mm_b_ack;
    logic [m*n*WORD_WIDTH-1:0] mm_C;
    logic                      mm_c_stb, mm_c_ack;

    modport slave (
        input  req_A0, req_A1, req_B0, req_B1, req_stb, rsp_ack,
               mm_a_ack, mm_b_ack, mm_C, mm_c_stb,
        output req_ack, rsp_C, rsp_stb, rsp_err,
               mm_A, mm_B, mm_a_stb, mm_b_stb, mm_c_ack
    );

    modport master (
        output req_A0, req_A1, req_B0, req_B1, req_stb, rsp_ack,
               mm_a_ack, mm_b_ack, mm_C, mm_c_stb,
        input  req_ack, rsp_C, rsp_stb, rsp_err,
               mm_A, mm_B, mm_a_stb, mm_b_stb, mm_c_ack
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin grant; the last-grant register resets to 1 so requester 0 wins first.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       update_i,
    input  logic       updIdx_i,
    output logic       grant_o,
    output logic       valid_o
);

    logic lastGrant_q, lastGrant_d;

    // History only matters when both requesters contend.
    always_comb begin
        grant_o     = 1'b0;
        lastGrant_d = lastGrant_q;
        if (req_i == 2'b11) begin
            grant_o = ~lastGrant_q;
        end else if (req_i[1]) begin
            grant_o = 1'b1;
        end
        if (update_i) begin
            lastGrant_d = updIdx_i;
        end
    end

    assign valid_o = |req_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lastGrant_q <= 1'b1;
        end else begin
            lastGrant_q <= lastGrant_d;
        end
    end

endmodule

// File: rtl/mm_arbiter.sv
// Round-robin arbiter sharing one matrix multiplier between two requesters.
// Define MM_ARB_TIMEOUT_EN to add a watchdog that aborts a stuck transaction with rsp_err.
module mm_arbiter
    import mm_pkg::*;
#(
    parameter int m       = 4,
    parameter int p       = 4,
    parameter int n       = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst,
    mm_arbiter_if.slave  bus
);

    localparam int AW = m * p * WORD_WIDTH;
    localparam int BW = p * n * WORD_WIDTH;
    localparam int CW = m * n * WORD_WIDTH;

    state_t          state_q, state_d;
    logic            owner_q;
    logic [AW-1:0]   mmA_q;
    logic [BW-1:0]   mmB_q;
    logic [CW-1:0]   rspC_q;
    logic [1:0]      reqAck_q;
    logic            aDone_q, bDone_q;

    logic            grant, grantValid;
    logic            retire, timeout;
    logic            mmAStb, mmBStb, mmCAck;
    logic [1:0]      rspStb;

    rr_arbiter2 uRr (
        .clk      (clk),
        .rst      (rst),
        .req_i    (bus.req_stb),
        .update_i (retire),
        .updIdx_i (owner_q),
        .grant_o  (grant),
        .valid_o  (grantValid)
    );

`ifdef MM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    // Counts cycles spent waiting on the multiplier; restarts every time the arbiter leaves it.
    assign timeout = ((state_q == ISSUE) || (state_q == BUSY)) && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if ((state_q == ISSUE) || (state_q == BUSY)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else begin
                cnt_q <= '0;
            end
            if (timeout) begin
                err_q <= 1'b1;
            end else if (retire) begin
                err_q <= 1'b0;
            end
        end
    end

    assign bus.rsp_err = err_q;
`else
    assign timeout     = 1'b0;
    assign bus.rsp_err = 1'b0;

    // TIMEOUT is inert without the watchdog.
    if (TIMEOUT < 1) begin : gInertTimeout
    end
`endif

    always_comb begin
        state_d = state_q;
        mmAStb  = 1'b0;
        mmBStb  = 1'b0;
        mmCAck  = 1'b0;
        rspStb  = 2'b00;
        retire  = 1'b0;
        case (state_q)
            IDLE: begin
                if (grantValid) state_d = ISSUE;
            end
            ISSUE: begin
                mmAStb = ~aDone_q;
                mmBStb = ~bDone_q;
                if (timeout) begin
                    state_d = RETURN;
                end else if ((aDone_q | bus.mm_a_ack) && (bDone_q | bus.mm_b_ack)) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                mmCAck = bus.mm_c_stb & ~timeout;
                if (timeout || bus.mm_c_stb) state_d = RETURN;
            end
            RETURN: begin
                rspStb = oneHot2(owner_q);
                retire = bus.rsp_ack[owner_q];
                if (retire) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operands are captured at grant so the requester may move on as soon as it is acked.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q  <= 1'b0;
            mmA_q    <= '0;
            mmB_q    <= '0;
            rspC_q   <= '0;
            reqAck_q <= 2'b00;
            aDone_q  <= 1'b0;
            bDone_q  <= 1'b0;
        end else begin
            reqAck_q <= 2'b00;
            if ((state_q == IDLE) && grantValid) begin
                owner_q  <= grant;
                mmA_q    <= grant ? bus.req_A1 : bus.req_A0;
                mmB_q    <= grant ? bus.req_B1 : bus.req_B0;
                reqAck_q <= oneHot2(grant);
                aDone_q  <= 1'b0;
                bDone_q  <= 1'b0;
            end
            if (state_q == ISSUE) begin
                if (bus.mm_a_ack) aDone_q <= 1'b1;
                if (bus.mm_b_ack) bDone_q <= 1'b1;
            end
            if (timeout) begin
                rspC_q <= '0;
            end else if (mmCAck) begin
                rspC_q <= bus.mm_C;
            end
        end
    end

    assign bus.req_ack  = reqAck_q;
    assign bus.rsp_stb  = rspStb;
    assign bus.rsp_C    = rspC_q;
    assign bus.mm_A     = mmA_q;
    assign bus.mm_B     = mmB_q;
    assign bus.mm_a_stb = mmAStb;
    assign bus.mm_b_stb = mmBStb;
    assign bus.mm_c_ack = mmCAck;

endmodule
